hier_stream_checker: RTL and testbench
======================================

Name: hier_stream_checker

Overview:
- Consumer/checker at the far end of the counter-plus-offset datapath.
- Samples a free-running count stream and two offset streams, each offset stream one register stage behind the count.
- Verifies sequence continuity and offset arithmetic, locks onto a clean stream, counts matches and errors, and raises a sticky fault after repeated consecutive mismatches.
- Instantiated beside the generator hierarchy as a self-checking monitor block.

Parameters:
WIDTH, 32, data width of all streams
OFFSET_A, 2, expected offset of stream A
OFFSET_B, 5, expected offset of stream B
SYNC_LEN, 2, consecutive clean samples needed to lock (1..15)
ERR_LIMIT, 4, consecutive mismatching samples that trigger fault (1..255)
CNT_W, 16, width of match/error counters

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  synchronous active-low reset
enable  input  1  checking enabled when high
clear  input  1  single-cycle pulse, clears counters and fault
count_in  input  WIDTH  count stream
plus_a_in  input  WIDTH  count delayed one cycle, plus OFFSET_A
plus_b_in  input  WIDTH  count delayed one cycle, plus OFFSET_B
locked  output  1  high while state is LOCKED
fault  output  1  sticky, ERR_LIMIT consecutive mismatches occurred
err_seq  output  1  one-cycle pulse, sequence mismatch
err_a  output  1  one-cycle pulse, stream A mismatch
err_b  output  1  one-cycle pulse, stream B mismatch
err_count  output  CNT_W  mismatching samples in LOCKED, saturating
match_count  output  CNT_W  clean samples in LOCKED, saturating

Behaviour:
- Reset: reset low at a posedge puts the block in state IDLE. All outputs are 0, prev_q = 0, sync_cnt = 0, consec = 0. Reset overrides enable and clear. Reset is not sampled between edges.
- Per-sample checks, all arithmetic mod 2^WIDTH:
  - seq_ok = count_in == prev_q + 1.
  - a_ok = plus_a_in == prev_q + OFFSET_A.
  - b_ok = plus_b_in == prev_q + OFFSET_B.
  - prev_q holds count_in from the previous enabled edge.
- Wrap: 0xFFFFFFFF -> 0 is a valid step. Offset sums wrap silently.
- IDLE:
  - enable=1: prev_q <= count_in, go to SYNC.
  - No checks run in IDLE.
- SYNC:
  - prev_q <= count_in every edge.
  - All three checks ok: sync_cnt increments. When sync_cnt reaches SYNC_LEN, go to LOCKED and clear sync_cnt.
  - Any check fails: sync_cnt <= 0. No error pulses and no counter updates.
- LOCKED:
  - prev_q <= count_in every edge. Resyncing on the observed value means a single jump gives one error, not a cascade.
  - Each err_* output is registered from its check failure and goes high in the cycle after the sampling edge, for one cycle.
  - Any failure: err_count +1 (saturating at all-ones) and consec +1.
  - Clean sample: match_count +1 (saturating) and consec <= 0.
  - consec reaching ERR_LIMIT: go to ERROR and set fault.
- ERROR:
  - locked = 0, fault = 1, no checks, err_* outputs = 0.
  - Leaves to IDLE only on enable=0 or clear=1.
- enable=0 in SYNC or LOCKED: next state IDLE, err_* outputs 0, counters hold.
- clear=1 (not in reset):
  - Zeroes err_count, match_count, consec and fault.
  - ERROR goes to IDLE; other states unaffected.
  - Clear wins over a same-edge increment or fault set.
- locked is registered: high in the cycle after the transition edge into LOCKED, low in the cycle after the transition edge out of it.

Test Plan:
1. Reset low 2 cycles, then enable=1 with count 10,11,12,…; plus_a = prev+2, plus_b = prev+5 -> locked=1 after 3rd enabled edge; match_count increments 1 per cycle; all err_* stay 0.
2. While locked, count 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000; plus_a 0x00000000 then 0x00000001; plus_b 0x00000003 then 0x00000004 -> no error pulses; match_count +3.
3. While locked, count jumps 20 -> 25, then 26, 27 with consistent plus_a/b (27, 28, …) -> err_seq high exactly one cycle; err_count=1; locked stays 1; following samples clean.
4. While locked, force plus_b wrong for 4 consecutive samples (ERR_LIMIT=4) -> 4 err_b pulses, err_count=4, fault=1, locked=0. Then enable=0 -> IDLE, fault stays 1. Then clear pulse -> fault=0, counters 0.
5. While locked with match_count=7, reset low for one edge -> all outputs 0. Re-enable -> relock after SYNC_LEN clean samples.
6. clear asserted on the same edge as a mismatch that would reach ERR_LIMIT -> err_count=0, fault=0, state stays LOCKED. Separately, a mismatch during SYNC -> no pulse, sync_cnt restarts, lock delayed accordingly.

Source files
------------

// File: rtl/hier_stream_checker.sv
`default_nettype none
// ============================================================================
//  Module      : hier_stream_checker
//  Description : Self-checking monitor for a count stream plus two offset
//                streams that lag the count by one register stage. Locks
//                onto a clean stream, counts matches and errors, and raises
//                a sticky fault after repeated consecutive mismatches.
//  Revision    : 1.0 - initial release
// ============================================================================
module hier_stream_checker #(
    parameter int WIDTH     = 32,
    parameter int OFFSET_A  = 2,
    parameter int OFFSET_B  = 5,
    parameter int SYNC_LEN  = 2,
    parameter int ERR_LIMIT = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] count_in,
    input  logic [WIDTH-1:0] plus_a_in,
    input  logic [WIDTH-1:0] plus_b_in,
    output logic             locked,
    output logic             fault,
    output logic             err_seq,
    output logic             err_a,
    output logic             err_b,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] match_count
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SYNC   = 2'd1;
    localparam logic [1:0] c_LOCKED = 2'd2;
    localparam logic [1:0] c_ERROR  = 2'd3;

    localparam logic [WIDTH-1:0] c_ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_OFF_A     = WIDTH'(OFFSET_A);
    localparam logic [WIDTH-1:0] c_OFF_B     = WIDTH'(OFFSET_B);
    localparam logic [3:0]       c_SYNC_LEN  = 4'(SYNC_LEN);
    localparam logic [7:0]       c_ERR_LIMIT = 8'(ERR_LIMIT);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_prev;
    logic [3:0]       r_sync_cnt;
    logic [7:0]       r_consec;
    logic             r_fault;
    logic             r_err_seq;
    logic             r_err_a;
    logic             r_err_b;
    logic [CNT_W-1:0] r_err_count;
    logic [CNT_W-1:0] r_match_count;

    logic             w_seq_ok;
    logic             w_a_ok;
    logic             w_b_ok;
    logic             w_all_ok;
    logic [3:0]       w_sync_inc;
    logic [7:0]       w_consec_inc;

    // Stream checks against the previous enabled sample; sums wrap mod 2^WIDTH.
    always_comb begin
        w_seq_ok     = (count_in  == r_prev + c_ONE);
        w_a_ok       = (plus_a_in == r_prev + c_OFF_A);
        w_b_ok       = (plus_b_in == r_prev + c_OFF_B);
        w_all_ok     = w_seq_ok && w_a_ok && w_b_ok;
        w_sync_inc   = r_sync_cnt + 4'd1;
        w_consec_inc = (r_consec == 8'hFF) ? r_consec : r_consec + 8'd1;
    end

    // State machine, sample history, error pulses and statistics.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= c_IDLE;
            r_prev        <= '0;
            r_sync_cnt    <= '0;
            r_consec      <= '0;
            r_fault       <= 1'b0;
            r_err_seq     <= 1'b0;
            r_err_a       <= 1'b0;
            r_err_b       <= 1'b0;
            r_err_count   <= '0;
            r_match_count <= '0;
        end else begin
            r_err_seq <= 1'b0;
            r_err_a   <= 1'b0;
            r_err_b   <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (enable) begin
                        r_prev     <= count_in;
                        r_sync_cnt <= '0;
                        r_state    <= c_SYNC;
                    end
                end
                c_SYNC: begin
                    if (!enable) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_prev <= count_in;
                        if (w_all_ok) begin
                            if (w_sync_inc >= c_SYNC_LEN) begin
                                r_sync_cnt <= '0;
                                r_state    <= c_LOCKED;
                            end else begin
                                r_sync_cnt <= w_sync_inc;
                            end
                        end else begin
                            r_sync_cnt <= '0;
                        end
                    end
                end
                c_LOCKED: begin
                    if (!enable) begin
                        r_state <= c_IDLE;
                    end else begin
                        // Resync on the observed value so a single jump costs one error.
                        r_prev    <= count_in;
                        r_err_seq <= !w_seq_ok;
                        r_err_a   <= !w_a_ok;
                        r_err_b   <= !w_b_ok;
                        if (!w_all_ok) begin
                            if (r_err_count != c_CNT_MAX) begin
                                r_err_count <= r_err_count + c_CNT_ONE;
                            end
                            r_consec <= w_consec_inc;
                            if (w_consec_inc >= c_ERR_LIMIT && !clear) begin
                                r_fault <= 1'b1;
                                r_state <= c_ERROR;
                            end
                        end else begin
                            if (r_match_count != c_CNT_MAX) begin
                                r_match_count <= r_match_count + c_CNT_ONE;
                            end
                            r_consec <= '0;
                        end
                    end
                end
                c_ERROR: begin
                    if (!enable || clear) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase

            // Clear takes priority over any same-edge increment or fault set.
            if (clear) begin
                r_err_count   <= '0;
                r_match_count <= '0;
                r_consec      <= '0;
                r_fault       <= 1'b0;
            end
        end
    end

    assign locked      = (r_state == c_LOCKED);
    assign fault       = r_fault;
    assign err_seq     = r_err_seq;
    assign err_a       = r_err_a;
    assign err_b       = r_err_b;
    assign err_count   = r_err_count;
    assign match_count = r_match_count;

endmodule
`default_nettype wire

// File: tb/tb_hier_stream_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hier_stream_checker
//  Description : Directed self-checking bench for hier_stream_checker.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hier_stream_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        clear;
    logic [31:0] count_in;
    logic [31:0] plus_a_in;
    logic [31:0] plus_b_in;
    logic        locked;
    logic        fault;
    logic        err_seq;
    logic        err_a;
    logic        err_b;
    logic [15:0] err_count;
    logic [15:0] match_count;

    logic [2:0]  errs;
    logic [31:0] last_cnt;
    int          n_checks = 0;
    int          n_errors = 0;

    assign errs = {err_seq, err_a, err_b};

    always #5 clk = ~clk;

    hier_stream_checker dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .clear       (clear),
        .count_in    (count_in),
        .plus_a_in   (plus_a_in),
        .plus_b_in   (plus_b_in),
        .locked      (locked),
        .fault       (fault),
        .err_seq     (err_seq),
        .err_a       (err_a),
        .err_b       (err_b),
        .err_count   (err_count),
        .match_count (match_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one sample; offsets follow the previously sent count unless corrupted.
    task automatic send(input logic [31:0] c, input logic bad_a, input logic bad_b);
        count_in  = c;
        plus_a_in = last_cnt + 32'd2 + {31'd0, bad_a};
        plus_b_in = last_cnt + 32'd5 + {31'd0, bad_b};
        last_cnt  = c;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; clear = 1'b1;
        count_in = 32'h1234; plus_a_in = 32'h55; plus_b_in = 32'hAA;
        step(); step();
        clear = 1'b0;
        n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL reset_locked got=%0b exp=0", locked); end
        n_checks++; if (fault !== 1'b0) begin n_errors++; $display("FAIL reset_fault got=%0b exp=0", fault); end
        n_checks++; if (errs !== 3'b000) begin n_errors++; $display("FAIL reset_errs got=%b exp=000", errs); end
        n_checks++; if (err_count !== 16'd0) begin n_errors++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
        n_checks++; if (match_count !== 16'd0) begin n_errors++; $display("FAIL reset_match_count got=%0d exp=0", match_count); end
    endtask

    task automatic test_lock();
        reset = 1'b1; enable = 1'b1; last_cnt = 32'd0;
        send(32'd10, 1'b0, 1'b0);
        n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL lock_edge1 got=%0b exp=0", locked); end
        send(32'd11, 1'b0, 1'b0);
        n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL lock_edge2 got=%0b exp=0", locked); end
        send(32'd12, 1'b0, 1'b0);
        n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL lock_edge3 got=%0b exp=1", locked); end
        n_checks++; if (match_count !== 16'd0) begin n_errors++; $display("FAIL lock_match0 got=%0d exp=0", match_count); end
        for (int i = 13; i <= 20; i++) begin
            send(32'(i), 1'b0, 1'b0);
            n_checks++; if (errs !== 3'b000) begin n_errors++; $display("FAIL lock_errs i=%0d got=%b exp=000", i, errs); end
            n_checks++; if (match_count !== 16'(i - 12)) begin n_errors++; $display("FAIL lock_match i=%0d got=%0d exp=%0d", i, match_count, i - 12); end
        end
    endtask

    task automatic test_seq_jump();
        send(32'd25, 1'b0, 1'b0);
        n_checks++; if (errs !== 3'b100) begin n_errors++; $display("FAIL jump_errs got=%b exp=100", errs); end
        n_checks++; if (err_count !== 16'd1) begin n_errors++; $display("FAIL jump_err_count got=%0d exp=1", err_count); end
        n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL jump_locked got=%0b exp=1", locked); end
        n_checks++; if (match_count !== 16'd8) begin n_errors++; $display("FAIL jump_match got=%0d exp=8", match_count); end
        send(32'd26, 1'b0, 1'b0);
        n_checks++; if (errs !== 3'b000) begin n_errors++; $display("FAIL jump_after_errs got=%b exp=000", errs); end
        n_checks++; if (match_count !== 16'd9) begin n_errors++; $display("FAIL jump_after_match got=%0d exp=9", match_count); end
        send(32'd27, 1'b0, 1'b0);
        n_checks++; if (match_count !== 16'd10) begin n_errors++; $display("FAIL jump_after2_match got=%0d exp=10", match_count); end
        n_checks++; if (err_count !== 16'd1) begin n_errors++; $display("FAIL jump_after2_err_count got=%0d exp=1", err_count); end
    endtask

    task automatic test_fault();
        clear = 1'b1;
        send(32'd28, 1'b0, 1'b0);
        clear = 1'b0;
        n_checks++; if (match_count !== 16'd0) begin n_errors++; $display("FAIL clrinc_match got=%0d exp=0", match_count); end
        n_checks++; if (err_count !== 16'd0) begin n_errors++; $display("FAIL clrinc_err_count got=%0d exp=0", err_count); end
        n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL clrinc_locked got=%0b exp=1", locked); end
        for (int k = 1; k <= 4; k++) begin
            send(32'(28 + k), 1'b0, 1'b1);
            n_checks++; if (errs !== 3'b001) begin n_errors++; $display("FAIL fault_errs k=%0d got=%b exp=001", k, errs); end
            n_checks++; if (err_count !== 16'(k)) begin n_errors++; $display("FAIL fault_err_count k=%0d got=%0d exp=%0d", k, err_count, k); end
            n_checks++; if (fault !== (k == 4)) begin n_errors++; $display("FAIL fault_flag k=%0d got=%0b exp=%0b", k, fault, k == 4); end
            n_checks++; if (locked !== (k != 4)) begin n_errors++; $display("FAIL fault_locked k=%0d got=%0b exp=%0b", k, locked, k != 4); end
        end
        send(32'd33, 1'b0, 1'b0);
        n_checks++; if (errs !== 3'b000) begin n_errors++; $display("FAIL error_state_errs got=%b exp=000", errs); end
        n_checks++; if (fault !== 1'b1) begin n_errors++; $display("FAIL error_state_fault got=%0b exp=1", fault); end
        n_checks++; if (err_count !== 16'd4) begin n_errors++; $display("FAIL error_state_err_count got=%0d exp=4", err_count); end
        enable = 1'b0;
        step();
        n_checks++; if (fault !== 1'b1) begin n_errors++; $display("FAIL idle_fault_sticky got=%0b exp=1", fault); end
        n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL idle_locked got=%0b exp=0", locked); end
        clear = 1'b1;
        step();
        clear = 1'b0;
        n_checks++; if (fault !== 1'b0) begin n_errors++; $display("FAIL clear_fault got=%0b exp=0", fault); end
        n_checks++; if (err_count !== 16'd0) begin n_errors++; $display("FAIL clear_err_count got=%0d exp=0", err_count); end
        n_checks++; if (match_count !== 16'd0) begin n_errors++; $display("FAIL clear_match got=%0d exp=0", match_count); end
    endtask

    task automatic test_wrap();
        enable = 1'b1;
        send(32'hFFFF_FFFA, 1'b0, 1'b0);
        send(32'hFFFF_FFFB, 1'b0, 1'b0);
        send(32'hFFFF_FFFC, 1'b0, 1'b0);
        n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL wrap_locked got=%0b exp=1", locked); end
        send(32'hFFFF_FFFD, 1'b0, 1'b0);
        n_checks++; if (match_count !== 16'd1) begin n_errors++; $display("FAIL wrap_match_pre got=%0d exp=1", match_count); end
        send(32'hFFFF_FFFE, 1'b0, 1'b0);
        n_checks++; if (errs !== 3'b000) begin n_errors++; $display("FAIL wrap_errs_fe got=%b exp=000", errs); end
        send(32'hFFFF_FFFF, 1'b0, 1'b0);
        n_checks++; if (errs !== 3'b000) begin n_errors++; $display("FAIL wrap_errs_ff got=%b exp=000", errs); end
        send(32'h0000_0000, 1'b0, 1'b0);
        n_checks++; if (errs !== 3'b000) begin n_errors++; $display("FAIL wrap_errs_00 got=%b exp=000", errs); end
        n_checks++; if (match_count !== 16'd4) begin n_errors++; $display("FAIL wrap_match got=%0d exp=4", match_count); end
        n_checks++; if (err_count !== 16'd0) begin n_errors++; $display("FAIL wrap_err_count got=%0d exp=0", err_count); end
        send(32'd1, 1'b0, 1'b0);
        send(32'd2, 1'b0, 1'b0);
        send(32'd3, 1'b0, 1'b0);
        n_checks++; if (match_count !== 16'd7) begin n_errors++; $display("FAIL wrap_match7 got=%0d exp=7", match_count); end
    endtask

    task automatic test_reset_locked();
        reset = 1'b0;
        step();
        n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL rst2_locked got=%0b exp=0", locked); end
        n_checks++; if (match_count !== 16'd0) begin n_errors++; $display("FAIL rst2_match got=%0d exp=0", match_count); end
        n_checks++; if ({fault, errs} !== 4'b0000) begin n_errors++; $display("FAIL rst2_flags got=%b exp=0000", {fault, errs}); end
        reset = 1'b1;
        send(32'd100, 1'b0, 1'b0);
        send(32'd101, 1'b0, 1'b0);
        n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL relock_early got=%0b exp=0", locked); end
        send(32'd102, 1'b0, 1'b0);
        n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL relock got=%0b exp=1", locked); end
    endtask

    task automatic test_clear_race();
        for (int k = 1; k <= 3; k++) begin
            send(32'(102 + k), 1'b1, 1'b0);
            n_checks++; if (errs !== 3'b010) begin n_errors++; $display("FAIL race_errs k=%0d got=%b exp=010", k, errs); end
            n_checks++; if (err_count !== 16'(k)) begin n_errors++; $display("FAIL race_err_count k=%0d got=%0d exp=%0d", k, err_count, k); end
        end
        clear = 1'b1;
        send(32'd106, 1'b1, 1'b0);
        clear = 1'b0;
        n_checks++; if (err_count !== 16'd0) begin n_errors++; $display("FAIL race_clr_err_count got=%0d exp=0", err_count); end
        n_checks++; if (fault !== 1'b0) begin n_errors++; $display("FAIL race_clr_fault got=%0b exp=0", fault); end
        n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL race_clr_locked got=%0b exp=1", locked); end
        send(32'd107, 1'b0, 1'b0);
        n_checks++; if (match_count !== 16'd1) begin n_errors++; $display("FAIL race_after_match got=%0d exp=1", match_count); end
        n_checks++; if ({locked, fault} !== 2'b10) begin n_errors++; $display("FAIL race_after_state got=%b exp=10", {locked, fault}); end
    endtask

    task automatic test_sync_mismatch();
        enable = 1'b0;
        step();
        n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL dis_locked got=%0b exp=0", locked); end
        n_checks++; if (match_count !== 16'd1) begin n_errors++; $display("FAIL dis_match_hold got=%0d exp=1", match_count); end
        enable = 1'b1;
        send(32'd200, 1'b0, 1'b0);
        send(32'd201, 1'b0, 1'b0);
        send(32'd205, 1'b0, 1'b0);
        n_checks++; if (errs !== 3'b000) begin n_errors++; $display("FAIL sync_mis_errs got=%b exp=000", errs); end
        n_checks++; if (err_count !== 16'd0) begin n_errors++; $display("FAIL sync_mis_err_count got=%0d exp=0", err_count); end
        n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL sync_mis_locked got=%0b exp=0", locked); end
        send(32'd206, 1'b0, 1'b0);
        n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL sync_delay_locked got=%0b exp=0", locked); end
        send(32'd207, 1'b0, 1'b0);
        n_checks++; if (locked !== 1'b1) begin n_errors++; $display("FAIL sync_relock got=%0b exp=1", locked); end
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; clear = 1'b0;
        count_in = '0; plus_a_in = '0; plus_b_in = '0; last_cnt = '0;
        test_reset();
        test_lock();
        test_seq_jump();
        test_fault();
        test_wrap();
        test_reset_locked();
        test_clear_race();
        test_sync_mismatch();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
